// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: EX operand forwarding from NUM_FWD later stages,
// plus a per-register latency scoreboard that stalls ID on RAW/WAW hazards.
module fwd_hazard_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int LAT_W    = 4,
  parameter int SEL_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  input  logic                       id_reg_write,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic [LAT_W-1:0]           id_lat,
  output logic                       id_stall,
  input  logic [NUM_SRC*REG_AW-1:0]  ex_rs,
  input  logic [NUM_FWD-1:0]         fwd_reg_write,
  input  logic [NUM_FWD*REG_AW-1:0]  fwd_rd,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
  output logic [31:0]                stall_cycles
);

  logic [LAT_W-1:0] r_cnt [NUM_REGS];
  logic [31:0]      r_stall_cycles;
  logic             w_raw;
  logic             w_waw;
  logic             w_stall;
  logic             w_issue;

  // Hazard detection against the scoreboard and issue qualification
  always_comb begin
    w_raw = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_raw = w_raw | (id_rs_used[s] && (id_rs[s*REG_AW +: REG_AW] != '0) &&
                       (r_cnt[id_rs[s*REG_AW +: REG_AW]] != '0));
    end
    // A younger write with a shorter latency must not overtake a pending one
    w_waw   = id_reg_write && (id_rd != '0) && (r_cnt[id_rd] > id_lat);
    w_stall = id_valid && (w_raw || w_waw);
    w_issue = id_valid && !w_stall && id_reg_write && (id_rd != '0) && (id_lat != '0);
  end

  assign id_stall     = w_stall;
  assign stall_cycles = r_stall_cycles;

  // Forwarding select: scan oldest to youngest so the youngest match wins
  always_comb begin
    ex_fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        ex_fwd_sel[s*SEL_W +: SEL_W] =
          (fwd_reg_write[i] && (fwd_rd[i*REG_AW +: REG_AW] != '0) &&
           (fwd_rd[i*REG_AW +: REG_AW] == ex_rs[s*REG_AW +: REG_AW]))
            ? SEL_W'(i + 1) : ex_fwd_sel[s*SEL_W +: SEL_W];
      end
    end
  end

  // Latency scoreboard: load on issue, otherwise count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == 0) begin
          r_cnt[r] <= '0;
        end else if (w_issue && (id_rd == REG_AW'(r))) begin
          r_cnt[r] <= id_lat;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - LAT_W'(1);
        end else begin
          r_cnt[r] <= r_cnt[r];
        end
      end
    end
  end

  // Saturating stall-cycle counter; survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: forwarding vector table plus
// scoreboard-checked stall sequences and an asynchronous reset case.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        id_reg_write;
  logic [4:0]  id_rd;
  logic [3:0]  id_lat;
  logic        id_stall;
  logic [9:0]  ex_rs;
  logic [1:0]  fwd_reg_write;
  logic [9:0]  fwd_rd;
  logic [3:0]  ex_fwd_sel;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;
  int unsigned exp_sc = 0;

  typedef struct {
    string       nm;
    logic        stall;
    logic [3:0]  sel;
    int unsigned sc;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    logic [4:0] rs0, rs1;
    logic [1:0] we;
    logic [4:0] rd0, rd1;
    logic [1:0] sel0, sel1;
  } vec_t;
  vec_t vecs [8];

  fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_reg_write(id_reg_write),
    .id_rd(id_rd), .id_lat(id_lat), .id_stall(id_stall), .ex_rs(ex_rs),
    .fwd_reg_write(fwd_reg_write), .fwd_rd(fwd_rd), .ex_fwd_sel(ex_fwd_sel),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: compare outputs mid-cycle against queued expectations
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, ".stall"}, {31'd0, id_stall}, {31'd0, e.stall});
      chk({e.nm, ".sel"}, {28'd0, ex_fwd_sel}, {28'd0, e.sel});
      chk({e.nm, ".cnt"}, stall_cycles, e.sc);
    end
  end

  task automatic push(input string nm, input logic st, input logic [3:0] sel);
    exp_t e;
    e.nm = nm; e.stall = st; e.sel = sel; e.sc = exp_sc;
    sb.push_back(e);
    if (st) exp_sc++;
  endtask

  // One ID cycle; forwarding inputs are idle so the select must be 0
  task automatic step(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] used, input logic we, input logic [4:0] rd,
                      input logic [3:0] lat, input logic fl, input logic exp_st,
                      input string nm);
    id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used; id_reg_write = we;
    id_rd = rd; id_lat = lat; flush = fl;
    ex_rs = '0; fwd_reg_write = '0; fwd_rd = '0;
    push(nm, exp_st, 4'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{5'd5,  5'd6,  2'b11, 5'd5,  5'd6,  2'd1, 2'd2};
    vecs[1] = '{5'd7,  5'd0,  2'b11, 5'd7,  5'd7,  2'd1, 2'd0};
    vecs[2] = '{5'd7,  5'd0,  2'b10, 5'd7,  5'd7,  2'd2, 2'd0};
    vecs[3] = '{5'd0,  5'd0,  2'b11, 5'd0,  5'd0,  2'd0, 2'd0};
    vecs[4] = '{5'd7,  5'd7,  2'b00, 5'd7,  5'd7,  2'd0, 2'd0};
    vecs[5] = '{5'd31, 5'd31, 2'b10, 5'd31, 5'd31, 2'd2, 2'd2};
    vecs[6] = '{5'd13, 5'd12, 2'b11, 5'd12, 5'd13, 2'd2, 2'd1};
    vecs[7] = '{5'd13, 5'd12, 2'b10, 5'd12, 5'd13, 2'd2, 2'd0};

    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    id_reg_write = 1'b0; id_rd = '0; id_lat = '0;
    ex_rs = {5'd6, 5'd5}; fwd_rd = {5'd6, 5'd5}; fwd_reg_write = 2'b11;
    #3;
    chk("reset.stall", {31'd0, id_stall}, 32'd0);
    chk("reset.cnt", stall_cycles, 32'd0);
    chk("reset.sel", {28'd0, ex_fwd_sel}, {28'd0, 2'd2, 2'd1});
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding table
    for (int k = 0; k < 8; k++) begin
      id_valid = 1'b0;
      ex_rs = {vecs[k].rs1, vecs[k].rs0};
      fwd_reg_write = vecs[k].we;
      fwd_rd = {vecs[k].rd1, vecs[k].rd0};
      push($sformatf("fwd%0d", k), 1'b0, {vecs[k].sel1, vecs[k].sel0});
      @(posedge clk); #1;
    end

    // Load-use, source slot 0 then slot 1, then unused operand
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 4'd1, 1'b0, 1'b0, "lu.issue");
    step(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, "lu.stall");
    step(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "lu.go");
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 4'd1, 1'b0, 1'b0, "lu1.issue");
    step(1'b1, 5'd0, 5'd3, 2'b10, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, "lu1.stall");
    step(1'b1, 5'd0, 5'd3, 2'b10, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "lu1.go");
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 4'd1, 1'b0, 1'b0, "nu.issue");
    step(1'b1, 5'd3, 5'd3, 2'b00, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "nu.nostall");

    // Multi-cycle WAW: ALU write to x4 waits out the lat-5 result
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 4'd5, 1'b0, 1'b0, "waw.issue");
    for (int k = 0; k < 5; k++)
      step(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd4, 4'd0, 1'b0, 1'b1, "waw.stall");
    step(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd4, 4'd0, 1'b0, 1'b0, "waw.go");

    // x0 sources never stall; equal latency is not a WAW hazard
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 4'd3, 1'b0, 1'b0, "x0.issue");
    step(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "x0.src");
    step(1'b1, 5'd4, 5'd0, 2'b01, 1'b1, 5'd4, 4'd2, 1'b0, 1'b1, "raw.cnt2");
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 4'd1, 1'b0, 1'b0, "waw.eq");
    step(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, "raw.reload");
    step(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "raw.go");

    // Maximum latency
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 4'd15, 1'b0, 1'b0, "max.issue");
    for (int k = 0; k < 15; k++)
      step(1'b1, 5'd0, 5'd10, 2'b10, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, "max.stall");
    step(1'b1, 5'd0, 5'd10, 2'b10, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "max.go");

    // Flush clears pending latency; flush beats a same-cycle issue
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 4'd8, 1'b0, 1'b0, "fl.issue");
    step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "fl.idle");
    step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 4'd0, 1'b1, 1'b0, "fl.flush");
    step(1'b1, 5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "fl.dep");
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd11, 4'd3, 1'b1, 1'b0, "fl.issueflush");
    step(1'b1, 5'd11, 5'd0, 2'b01, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "fl.dep2");

    // Asynchronous reset in the middle of a stall
    step(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 4'd6, 1'b0, 1'b0, "ar.issue");
    step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "ar.idle1");
    step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "ar.idle2");
    id_valid = 1'b1; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01; id_reg_write = 1'b0;
    #1 chk("ar.pre", {31'd0, id_stall}, 32'd1);
    rst_n = 1'b0;
    #1 chk("ar.stall", {31'd0, id_stall}, 32'd0);
    chk("ar.cnt", stall_cycles, 32'd0);
    exp_sc = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "ar.after");
    step(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, "end");

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
